// File: rtl/interval_timer.sv
// Interval timer: a prescaler produces a base tick and a loadable down-counter counts ticks.
// Supports one-shot and periodic modes, pause/resume, abort, and remaining-count readout.
module interval_timer #(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned TICK_US = 1000,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             mode,
  input  logic [CNT_W-1:0] period,
  output logic             tick,
  output logic             done,
  output logic             busy,
  output logic [CNT_W-1:0] remaining
);

  localparam int unsigned PRESCALE = CLK_HZ / 1_000_000 * TICK_US;
  localparam int unsigned PS_W     = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_PAUSED = 2'd2;

  logic [1:0]       r_state;
  logic [PS_W-1:0]  r_presc;
  logic [CNT_W-1:0] r_rem;
  logic [CNT_W-1:0] r_period;
  logic             r_mode;
  logic             r_tick;
  logic             r_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_presc  <= '0;
      r_rem    <= '0;
      r_period <= '0;
      r_mode   <= 1'b0;
      r_tick   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      r_done <= 1'b0;
      if (stop) begin
        r_state <= S_IDLE;
        r_presc <= '0;
        r_rem   <= '0;
      end else if (start) begin
        r_presc <= '0;
        if (period != '0) begin
          r_rem    <= period;
          r_period <= period;
          r_mode   <= mode;
          r_state  <= pause ? S_PAUSED : S_RUN;
        end else begin
          r_rem   <= '0;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
      end else if (r_state != S_IDLE) begin
        // The resume edge itself counts, so a pause of N cycles delays expiry by exactly N.
        if (pause) begin
          r_state <= S_PAUSED;
        end else begin
          r_state <= S_RUN;
          if (r_presc == PS_LAST) begin
            r_presc <= '0;
            r_tick  <= 1'b1;
            if (r_rem > CNT_W'(1)) begin
              r_rem <= r_rem - CNT_W'(1);
            end else begin
              r_done <= 1'b1;
              if (r_mode) begin
                r_rem <= r_period;
              end else begin
                r_rem   <= '0;
                r_state <= S_IDLE;
              end
            end
          end else begin
            r_presc <= r_presc + PS_W'(1);
          end
        end
      end
    end
  end

  assign tick      = r_tick;
  assign done      = r_done;
  assign busy      = (r_state != S_IDLE);
  assign remaining = r_rem;

endmodule

// File: tb/tb_interval_timer.sv
// Directed bench for interval_timer with PRESCALE=4, CNT_W=8; expectations are hand-derived.
module tb_interval_timer;

  localparam int unsigned CNT_W = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             stop;
  logic             pause;
  logic             mode;
  logic [CNT_W-1:0] period;
  logic             tick;
  logic             done;
  logic             busy;
  logic [CNT_W-1:0] remaining;

  int unsigned n_cmp;
  int unsigned n_err;
  int unsigned n_done;

  interval_timer #(
    .CLK_HZ (1_000_000),
    .TICK_US(4),
    .CNT_W  (CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .stop     (stop),
    .pause    (pause),
    .mode     (mode),
    .period   (period),
    .tick     (tick),
    .done     (done),
    .busy     (busy),
    .remaining(remaining)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents start for one edge (edge k); returns 1 time unit after edge k.
  task automatic do_start(input int unsigned per, input logic m);
    period = CNT_W'(per);
    mode   = m;
    start  = 1'b1;
    step();
    start  = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0; mode = 1'b0; period = '0;
    #2;
    check("rst_busy", busy, 0);
    check("rst_rem", remaining, 0);
    check("rst_tick", tick, 0);
    check("rst_done", done, 0);
    #10 rst_n = 1'b1;
    step();

    // 1: one-shot, period 3
    do_start(3, 1'b0);
    check("t1_busy0", busy, 1);
    check("t1_rem0", remaining, 3);
    for (int n = 1; n <= 12; n++) begin
      step();
      check("t1_tick", tick, (n % 4 == 0) ? 1 : 0);
      check("t1_done", done, (n == 12) ? 1 : 0);
      check("t1_rem", remaining, (n < 4) ? 3 : (n < 8) ? 2 : (n < 12) ? 1 : 0);
      check("t1_busy", busy, (n < 12) ? 1 : 0);
    end
    step();
    check("t1_done_clr", done, 0);

    // 2: periodic, period 2, five periods
    do_start(2, 1'b1);
    for (int n = 1; n <= 40; n++) begin
      step();
      check("t2_done", done, (n % 8 == 0) ? 1 : 0);
      check("t2_rem", remaining, (n % 8 < 4) ? 2 : 1);
      check("t2_busy", busy, 1);
    end
    stop = 1'b1; step(); stop = 1'b0;
    check("t2_stop_busy", busy, 0);

    // 3: pause sampled at edges +6..+15, period 5 -> done at +30
    do_start(5, 1'b0);
    for (int n = 1; n <= 30; n++) begin
      pause = (n >= 6 && n <= 15);
      step();
      check("t3_done", done, (n == 30) ? 1 : 0);
      if (n >= 6 && n <= 15) begin
        check("t3_tick_paused", tick, 0);
        check("t3_rem_frozen", remaining, 4);
        check("t3_busy_paused", busy, 1);
      end
    end
    pause = 1'b0;
    check("t3_rem_end", remaining, 0);
    check("t3_busy_end", busy, 0);

    // 4: stop on edge +7 of period 3, then restart from zero
    do_start(3, 1'b0);
    for (int n = 1; n <= 6; n++) step();
    stop = 1'b1; step(); stop = 1'b0;
    check("t4_busy", busy, 0);
    check("t4_rem", remaining, 0);
    n_done = 0;
    for (int n = 1; n <= 12; n++) begin
      step();
      n_done += done;
    end
    check("t4_no_done", n_done, 0);
    do_start(3, 1'b0);
    for (int n = 1; n <= 12; n++) begin
      step();
      check("t4_restart_done", done, (n == 12) ? 1 : 0);
    end

    // 5: retrigger at edge +10 with period 2 -> done 8 edges after retrigger only
    do_start(3, 1'b0);
    for (int n = 1; n <= 9; n++) step();
    do_start(2, 1'b0);
    check("t5_rem_reload", remaining, 2);
    for (int n = 1; n <= 10; n++) begin
      step();
      check("t5_done", done, (n == 8) ? 1 : 0);
    end

    // 6a: period 0 -> single done, never busy
    do_start(0, 1'b0);
    check("t6_zero_done", done, 1);
    check("t6_zero_busy", busy, 0);
    n_done = 0;
    for (int n = 1; n <= 6; n++) begin
      step();
      n_done += done;
      check("t6_zero_busy_n", busy, 0);
    end
    check("t6_zero_ndone", n_done, 0);

    // 6b: asynchronous reset mid-run
    do_start(3, 1'b1);
    for (int n = 1; n <= 4; n++) step();
    check("t6_pre_rst_rem", remaining, 2);
    rst_n = 1'b0;
    #1;
    check("t6_rst_busy", busy, 0);
    check("t6_rst_rem", remaining, 0);
    check("t6_rst_tick", tick, 0);
    check("t6_rst_done", done, 0);
    #2 rst_n = 1'b1;
    step();

    // 6c: stop and start together -> idle
    stop = 1'b1;
    do_start(3, 1'b0);
    stop = 1'b0;
    check("t6_ss_busy", busy, 0);
    check("t6_ss_rem", remaining, 0);
    step();
    check("t6_ss_busy2", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
